shift_reg_responder: RTL and testbench

Command-driven universal shift register. It is the receiving end of the load / shift_left_right / data_in control interface that our stimulus tasks drive.
- Accepts one command per valid/ready handshake: either a parallel load or a multi-bit shift left or right.
- A shift executes one bit per clock, with serial fill and serial output.
- Sits between a command source (bench task or controller FSM) and downstream logic that consumes the parallel word and the serial stream.

---
 rtl/shift_reg_responder.sv | 109 ++++++++++
 tb/tb_shift_reg_responder.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_reg_responder.sv
// Command-driven universal shift register.
// Parallel load or N-bit left/right shift, one bit per clock.
module shift_reg_responder #(
  parameter int REG_WIDTH       = 8,
  parameter int SHIFT_CNT_WIDTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_cmd_valid,
  output logic                       o_cmd_ready,
  input  logic                       i_load,
  input  logic                       i_shift_left_right,
  input  logic [REG_WIDTH-1:0]       i_data_in,
  input  logic [SHIFT_CNT_WIDTH-1:0] i_shift_amt,
  input  logic                       i_serial_in,
  output logic [REG_WIDTH-1:0]       o_data_out,
  output logic                       o_serial_out,
  output logic                       o_busy,
  output logic                       o_done
);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t                     state;
  state_t                     state_nxt;
  logic [SHIFT_CNT_WIDTH-1:0] cnt;
  logic                       dir_left;
  logic                       accept;
  logic                       last_shift;
  logic                       zero_amt;

  assign accept     = i_cmd_valid && o_cmd_ready;
  assign zero_amt   = (i_shift_amt == '0);
  assign last_shift = (cnt == SHIFT_CNT_WIDTH'(1));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state: only a nonzero shift leaves IDLE
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (accept && !i_load && !zero_amt)
          state_nxt = SHIFT;
      end
      SHIFT: begin
        if (last_shift)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake and status outputs decoded from state
  always_comb begin
    o_cmd_ready = 1'b0;
    o_busy      = 1'b0;
    unique case (state)
      IDLE:    o_cmd_ready = !rst;
      SHIFT:   o_busy      = 1'b1;
      default: o_cmd_ready = 1'b0;
    endcase
  end

  // Datapath: load, latch shift command, shift one bit per edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_data_out   <= '0;
      o_serial_out <= 1'b0;
      o_done       <= 1'b0;
      cnt          <= '0;
      dir_left     <= 1'b0;
    end else begin
      o_done <= 1'b0;
      if (state == IDLE) begin
        if (accept) begin
          if (i_load) begin
            o_data_out <= i_data_in;
            o_done     <= 1'b1;
          end else if (zero_amt) begin
            o_done <= 1'b1;
          end else begin
            cnt      <= i_shift_amt;
            dir_left <= i_shift_left_right;
          end
        end
      end else begin
        if (dir_left) begin
          o_data_out   <= {o_data_out[REG_WIDTH-2:0], i_serial_in};
          o_serial_out <= o_data_out[REG_WIDTH-1];
        end else begin
          o_data_out   <= {i_serial_in, o_data_out[REG_WIDTH-1:1]};
          o_serial_out <= o_data_out[0];
        end
        cnt <= cnt - SHIFT_CNT_WIDTH'(1);
        if (last_shift)
          o_done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_shift_reg_responder.sv
// Self-checking bench for shift_reg_responder.
// Directed table, corner sequences, random commands vs model.
module tb_shift_reg_responder;

  logic       clk;
  logic       rst;
  logic       i_cmd_valid;
  logic       o_cmd_ready;
  logic       i_load;
  logic       i_shift_left_right;
  logic [7:0] i_data_in;
  logic [3:0] i_shift_amt;
  logic       i_serial_in;
  logic [7:0] o_data_out;
  logic       o_serial_out;
  logic       o_busy;
  logic       o_done;

  int total = 0;
  int bad   = 0;

  logic [7:0] md;
  logic       ms;

  shift_reg_responder #(
    .REG_WIDTH(8),
    .SHIFT_CNT_WIDTH(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .i_cmd_valid(i_cmd_valid),
    .o_cmd_ready(o_cmd_ready),
    .i_load(i_load),
    .i_shift_left_right(i_shift_left_right),
    .i_data_in(i_data_in),
    .i_shift_amt(i_shift_amt),
    .i_serial_in(i_serial_in),
    .o_data_out(o_data_out),
    .o_serial_out(o_serial_out),
    .o_busy(o_busy),
    .o_done(o_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       ld;
    logic       lr;
    logic [7:0] din;
    logic [3:0] amt;
    int         sm;
    logic [7:0] xd;
    logic       xs;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: one shift computed with plain arithmetic
  function automatic void mshift(input logic lr, input logic s);
    int v;
    v = int'(md);
    if (lr) begin
      ms = logic'((v / 128) % 2);
      md = 8'((v * 2 + int'(s)) % 256);
    end else begin
      ms = logic'(v % 2);
      md = 8'(v / 2 + int'(s) * 128);
    end
  endfunction

  // sm: 0/1 constant serial fill, 2 random fill
  task automatic run_cmd(input logic ld, input logic lr,
                         input logic [7:0] din, input logic [3:0] amt,
                         input int sm, input string nm);
    int   edges;
    int   want;
    logic s;
    i_cmd_valid        = 1'b1;
    i_load             = ld;
    i_shift_left_right = lr;
    i_data_in          = din;
    i_shift_amt        = amt;
    chk({nm, "_ready"}, 32'(o_cmd_ready), 32'd1);
    step();
    i_cmd_valid = 1'b0;
    i_data_in   = $urandom;
    edges       = 1;
    if (ld) md = din;
    chk({nm, "_acc_data"}, 32'(o_data_out), 32'(md));
    while (!o_done && edges < 40) begin
      chk({nm, "_busy"}, {o_busy, o_cmd_ready}, 32'b10);
      s = (sm == 2) ? logic'($urandom % 2) : logic'(sm & 1);
      i_serial_in = s;
      step();
      edges++;
      mshift(lr, s);
      chk({nm, "_data"}, 32'(o_data_out), 32'(md));
      chk({nm, "_sout"}, 32'(o_serial_out), 32'(ms));
    end
    want = (ld || amt == 0) ? 1 : int'(amt) + 1;
    chk({nm, "_latency"}, 32'(edges), 32'(want));
    chk({nm, "_done"}, {o_done, o_busy, o_cmd_ready}, 32'b101);
    step();
    chk({nm, "_done_pulse"}, 32'(o_done), 32'd0);
  endtask

  initial begin
    int edges;
    tbl[0] = '{1'b1, 1'b0, 8'hA5, 4'd0,  0, 8'hA5, 1'b0};
    tbl[1] = '{1'b0, 1'b1, 8'h00, 4'd1,  0, 8'h4A, 1'b1};
    tbl[2] = '{1'b1, 1'b0, 8'h01, 4'd0,  0, 8'h01, 1'b1};
    tbl[3] = '{1'b0, 1'b0, 8'h00, 4'd3,  1, 8'hE0, 1'b0};
    tbl[4] = '{1'b1, 1'b0, 8'hFF, 4'd0,  0, 8'hFF, 1'b0};
    tbl[5] = '{1'b0, 1'b1, 8'h00, 4'd10, 0, 8'h00, 1'b0};
    tbl[6] = '{1'b0, 1'b0, 8'h00, 4'd0,  1, 8'h00, 1'b0};
    tbl[7] = '{1'b1, 1'b0, 8'h81, 4'd0,  0, 8'h81, 1'b0};
    tbl[8] = '{1'b0, 1'b0, 8'h00, 4'd8,  1, 8'hFF, 1'b1};
    tbl[9] = '{1'b0, 1'b1, 8'h00, 4'd15, 1, 8'hFF, 1'b1};

    rst                = 1'b1;
    i_cmd_valid        = 1'b0;
    i_load             = 1'b0;
    i_shift_left_right = 1'b0;
    i_data_in          = 8'h00;
    i_shift_amt        = 4'd0;
    i_serial_in        = 1'b0;
    md                 = 8'h00;
    ms                 = 1'b0;
    #23;
    rst = 1'b0;
    step();
    chk("rst_state",
        {o_data_out, o_serial_out, o_busy, o_done, o_cmd_ready},
        {8'h00, 4'b0001});

    for (int i = 0; i < 10; i++) begin
      run_cmd(tbl[i].ld, tbl[i].lr, tbl[i].din, tbl[i].amt,
              tbl[i].sm, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d_final", i),
          {o_data_out, o_serial_out}, {tbl[i].xd, tbl[i].xs});
    end

    // Held command during a long shift waits for the done cycle
    run_cmd(1'b1, 1'b0, 8'hFF, 4'd0, 0, "t4_ld");
    i_cmd_valid        = 1'b1;
    i_load             = 1'b0;
    i_shift_left_right = 1'b1;
    i_shift_amt        = 4'd10;
    i_serial_in        = 1'b0;
    step();
    i_load    = 1'b1;
    i_data_in = 8'h3C;
    edges     = 1;
    while (!o_done && edges < 40) begin
      chk("t4_not_ready", 32'(o_cmd_ready), 32'd0);
      step();
      edges++;
      mshift(1'b1, 1'b0);
      chk("t4_data", 32'(o_data_out), 32'(md));
    end
    chk("t4_latency", 32'(edges), 32'd11);
    chk("t4_done_ready", {o_data_out, o_done, o_cmd_ready},
        {8'h00, 2'b11});
    step();
    i_cmd_valid = 1'b0;
    md          = 8'h3C;
    chk("t4_held_load", {o_data_out, o_done}, {8'h3C, 1'b1});
    step();
    chk("t4_done_clear", 32'(o_done), 32'd0);

    // Zero shift then immediate load: consecutive done pulses
    i_cmd_valid = 1'b1;
    i_load      = 1'b0;
    i_shift_amt = 4'd0;
    step();
    chk("t5_n0", {o_data_out, o_done, o_cmd_ready, o_busy},
        {8'h3C, 3'b110});
    i_load    = 1'b1;
    i_data_in = 8'd1;
    step();
    i_cmd_valid = 1'b0;
    md          = 8'h01;
    chk("t5_load", {o_data_out, o_done}, {8'h01, 1'b1});
    step();
    chk("t5_done_clear", 32'(o_done), 32'd0);

    // Async reset in the middle of a shift of 5
    run_cmd(1'b1, 1'b0, 8'hA5, 4'd0, 0, "t6_ld");
    i_cmd_valid        = 1'b1;
    i_load             = 1'b0;
    i_shift_left_right = 1'b1;
    i_shift_amt        = 4'd5;
    i_serial_in        = 1'b1;
    step();
    i_cmd_valid = 1'b0;
    step();
    step();
    chk("t6_mid_busy", 32'(o_busy), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_async_clear",
        {o_data_out, o_serial_out, o_busy, o_done},
        {8'h00, 3'b000});
    #3;
    rst = 1'b0;
    md  = 8'h00;
    ms  = 1'b0;
    step();
    chk("t6_after", {o_cmd_ready, o_busy, o_done, o_data_out},
        {3'b100, 8'h00});
    for (int i = 0; i < 6; i++) begin
      step();
      chk("t6_no_done", {o_done, o_busy}, 32'd0);
    end

    // Random commands against the model
    for (int i = 0; i < 40; i++) begin
      run_cmd(logic'(($urandom % 4) == 0), logic'($urandom % 2),
              8'($urandom), 4'($urandom), 2,
              $sformatf("rnd%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
